// File: rtl/axis_frame_len_gen.sv
// AXI4-Stream test frame generator: accepts a length command (in words) and
// emits one frame of exactly that many words with an incrementing word pattern,
// thermometer tkeep on the final beat and tlast.
module axis_frame_len_gen #(
    parameter int DATA_WIDTH  = 64,
    parameter bit KEEP_ENABLE = (DATA_WIDTH > 8),
    parameter int KEEP_WIDTH  = (DATA_WIDTH / 8),
    parameter int LEN_WIDTH   = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [LEN_WIDTH-1:0]  s_len,
    input  logic                  s_len_valid,
    output logic                  s_len_ready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy
);

    // With tkeep disabled the whole bus is a single word.
    localparam int LANES = KEEP_ENABLE ? KEEP_WIDTH : 1;
    localparam int LW    = DATA_WIDTH / LANES;
    localparam logic [LEN_WIDTH-1:0] LANES_L = LEN_WIDTH'(LANES);
    localparam logic [LEN_WIDTH-1:0] KEEP_L  = LEN_WIDTH'(KEEP_WIDTH);

    typedef enum logic {StIdle, StSend} state_t;

    state_t                state_q, state_d;
    logic [LEN_WIDTH-1:0]  rem_q, rem_d;
    logic [LEN_WIDTH-1:0]  w_q, w_d;
    logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
    logic [KEEP_WIDTH-1:0] tkeep_q, tkeep_d;
    logic                  tlast_q, tlast_d;
    logic                  tvalid_q, tvalid_d;

    logic [LEN_WIDTH-1:0]  n_cur, rem_adv, w_adv;
    logic [LEN_WIDTH-1:0]  src_rem, src_w, src_n;
    logic [DATA_WIDTH-1:0] beat_data;
    logic [KEEP_WIDTH-1:0] beat_keep;
    logic                  beat_last;

    // Counter values after the currently presented beat is consumed.
    always_comb begin
        n_cur   = (rem_q < LANES_L) ? rem_q : LANES_L;
        rem_adv = rem_q - n_cur;
        w_adv   = w_q + n_cur;
    end

    // Build the next beat from either a fresh command or the advanced counters.
    always_comb begin
        src_rem   = (state_q == StIdle) ? s_len : rem_adv;
        src_w     = (state_q == StIdle) ? '0 : w_adv;
        src_n     = (src_rem < LANES_L) ? src_rem : LANES_L;
        beat_data = '0;
        for (int k = 0; k < LANES; k++) begin
            if (LEN_WIDTH'(k) < src_n) begin
                beat_data[k*LW +: LW] = LW'(src_w + LEN_WIDTH'(k));
            end
        end
        if (KEEP_ENABLE) begin
            beat_keep = {KEEP_WIDTH{1'b1}} >> (KEEP_L - src_n);
        end else begin
            beat_keep = {KEEP_WIDTH{1'b1}};
        end
        beat_last = (src_rem <= LANES_L);
    end

    // Next-state: accept commands in idle, advance on each accepted beat.
    always_comb begin
        state_d  = state_q;
        rem_d    = rem_q;
        w_d      = w_q;
        tdata_d  = tdata_q;
        tkeep_d  = tkeep_q;
        tlast_d  = tlast_q;
        tvalid_d = tvalid_q;
        unique case (state_q)
            StIdle: begin
                // A zero-length command is consumed without emitting anything.
                if (s_len_valid && (s_len != '0)) begin
                    state_d  = StSend;
                    rem_d    = s_len;
                    w_d      = '0;
                    tdata_d  = beat_data;
                    tkeep_d  = beat_keep;
                    tlast_d  = beat_last;
                    tvalid_d = 1'b1;
                end
            end
            StSend: begin
                if (m_axis_tready) begin
                    rem_d = rem_adv;
                    w_d   = w_adv;
                    if (rem_adv == '0) begin
                        state_d  = StIdle;
                        w_d      = '0;
                        tdata_d  = '0;
                        tkeep_d  = '0;
                        tlast_d  = 1'b0;
                        tvalid_d = 1'b0;
                    end else begin
                        tdata_d = beat_data;
                        tkeep_d = beat_keep;
                        tlast_d = beat_last;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; reset overrides any concurrent handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            rem_q    <= '0;
            w_q      <= '0;
            tdata_q  <= '0;
            tkeep_q  <= '0;
            tlast_q  <= 1'b0;
            tvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rem_q    <= rem_d;
            w_q      <= w_d;
            tdata_q  <= tdata_d;
            tkeep_q  <= tkeep_d;
            tlast_q  <= tlast_d;
            tvalid_q <= tvalid_d;
        end
    end

    assign s_len_ready   = (state_q == StIdle);
    assign busy          = (state_q == StSend);
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tkeep  = tkeep_q;
    assign m_axis_tlast  = tlast_q;
    assign m_axis_tvalid = tvalid_q;

endmodule

// File: tb/tb_axis_frame_len_gen.sv
// Directed testbench for axis_frame_len_gen with a small frame-length monitor
// on the output for the loopback scenario.
module tb_axis_frame_len_gen;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] s_len = '0;
    logic        s_len_valid = 1'b0;
    logic        s_len_ready;
    logic [63:0] m_axis_tdata;
    logic [7:0]  m_axis_tkeep;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic        m_axis_tlast;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    axis_frame_len_gen dut (
        .clk          (clk),
        .rst          (rst),
        .s_len        (s_len),
        .s_len_valid  (s_len_valid),
        .s_len_ready  (s_len_ready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast (m_axis_tlast),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Frame-length monitor: sums enabled lanes, reports on tlast.
    int mon_acc = 0;
    int mon_len = 0;
    int mon_count = 0;
    always @(posedge clk) begin
        if (rst) begin
            mon_acc = 0;
        end else if (m_axis_tvalid && m_axis_tready) begin
            if (m_axis_tlast) begin
                mon_len   = mon_acc + $countones(m_axis_tkeep);
                mon_acc   = 0;
                mon_count = mon_count + 1;
            end else begin
                mon_acc = mon_acc + $countones(m_axis_tkeep);
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a command and hold it until accepted (bounded).
    task automatic send_cmd(input int len);
        s_len       = 16'(len);
        s_len_valid = 1'b1;
        for (int i = 0; i < 50 && !s_len_ready; i++) tick;
        n_checks++;
        if (s_len_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_cmd_ready: s_len_ready=%b required 1", s_len_ready);
        end
        tick;
        s_len_valid = 1'b0;
    endtask

    // Consume one frame of len words; mode 0 tready=1, 1 fixed pattern, 2 random.
    task automatic collect(input int len, input int mode, output int beats,
                           output logic [7:0] last_keep);
        int          rem, b, cyc, n;
        logic        done, stalled, prev_l;
        logic [63:0] exp_d, prev_d;
        logic [7:0]  exp_k, prev_k;
        logic [5:0]  pat;
        pat = 6'b101001;
        rem = len; b = 0; beats = 0; cyc = 0; done = 0; stalled = 0;
        prev_d = '0; prev_k = '0; prev_l = 0; last_keep = '0;
        while (!done && cyc < len + 20000) begin
            case (mode)
                0:       m_axis_tready = 1'b1;
                1:       m_axis_tready = (cyc < 6) ? pat[cyc] : 1'b1;
                default: m_axis_tready = 1'($urandom_range(0, 1));
            endcase
            n_checks++;
            if (m_axis_tvalid !== 1'b1) begin
                n_fail++;
                $display("FAIL collect_tvalid: tvalid=%b required 1 (len=%0d beat=%0d)",
                         m_axis_tvalid, len, beats);
                done = 1;
            end else begin
                if (stalled) begin
                    n_checks++;
                    if ({m_axis_tdata, m_axis_tkeep, m_axis_tlast} !== {prev_d, prev_k, prev_l}) begin
                        n_fail++;
                        $display("FAIL collect_stable: data=%h keep=%h last=%b required %h %h %b",
                                 m_axis_tdata, m_axis_tkeep, m_axis_tlast, prev_d, prev_k, prev_l);
                    end
                end
                if (m_axis_tready) begin
                    n = (rem < 8) ? rem : 8;
                    exp_k = 8'hFF >> (8 - n);
                    exp_d = '0;
                    for (int k = 0; k < 8; k++) begin
                        exp_d[8*k +: 8] = (k < n) ? 8'((b + k) % 256) : 8'h00;
                    end
                    n_checks++;
                    if (m_axis_tkeep !== exp_k) begin
                        n_fail++;
                        $display("FAIL collect_keep: keep=%h required %h (beat=%0d)",
                                 m_axis_tkeep, exp_k, beats);
                    end
                    n_checks++;
                    if (m_axis_tdata !== exp_d) begin
                        n_fail++;
                        $display("FAIL collect_data: data=%h required %h (beat=%0d)",
                                 m_axis_tdata, exp_d, beats);
                    end
                    n_checks++;
                    if (m_axis_tlast !== (rem <= 8)) begin
                        n_fail++;
                        $display("FAIL collect_last: last=%b required %b (beat=%0d)",
                                 m_axis_tlast, (rem <= 8), beats);
                    end
                    b = b + n;
                    rem = rem - n;
                    beats++;
                    last_keep = m_axis_tkeep;
                    if (rem == 0) done = 1;
                end
                stalled = !m_axis_tready;
                prev_d = m_axis_tdata; prev_k = m_axis_tkeep; prev_l = m_axis_tlast;
            end
            tick;
            cyc++;
        end
        m_axis_tready = 1'b1;
        n_checks++;
        if (rem != 0) begin
            n_fail++;
            $display("FAIL collect_done: %0d words outstanding required 0", rem);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        tick; tick;
        rst = 1'b0;
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_tvalid: %b required 0", m_axis_tvalid); end
        n_checks++;
        if (m_axis_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_tlast: %b required 0", m_axis_tlast); end
        n_checks++;
        if (m_axis_tkeep !== 8'h00) begin n_fail++; $display("FAIL reset_tkeep: %h required 00", m_axis_tkeep); end
        n_checks++;
        if (m_axis_tdata !== 64'h0) begin n_fail++; $display("FAIL reset_tdata: %h required 0", m_axis_tdata); end
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: %b required 0", busy); end
        n_checks++;
        if (s_len_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: %b required 1", s_len_ready); end
    endtask

    task automatic test_frame20;
        logic [63:0] exp_d [3];
        logic [7:0]  exp_k [3];
        exp_d[0] = 64'h0706_0504_0302_0100; exp_k[0] = 8'hFF;
        exp_d[1] = 64'h0F0E_0D0C_0B0A_0908; exp_k[1] = 8'hFF;
        exp_d[2] = 64'h0000_0000_1312_1110; exp_k[2] = 8'h0F;
        m_axis_tready = 1'b1;
        send_cmd(20);
        n_checks++;
        if (busy !== 1'b1 || s_len_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL f20_busy: busy=%b ready=%b required 1 0", busy, s_len_ready);
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (m_axis_tvalid !== 1'b1) begin n_fail++; $display("FAIL f20_tvalid[%0d]: %b required 1", i, m_axis_tvalid); end
            n_checks++;
            if (m_axis_tdata !== exp_d[i]) begin n_fail++; $display("FAIL f20_data[%0d]: %h required %h", i, m_axis_tdata, exp_d[i]); end
            n_checks++;
            if (m_axis_tkeep !== exp_k[i]) begin n_fail++; $display("FAIL f20_keep[%0d]: %h required %h", i, m_axis_tkeep, exp_k[i]); end
            n_checks++;
            if (m_axis_tlast !== (i == 2)) begin n_fail++; $display("FAIL f20_last[%0d]: %b required %b", i, m_axis_tlast, (i == 2)); end
            tick;
        end
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || s_len_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL f20_end: tvalid=%b ready=%b busy=%b required 0 1 0",
                     m_axis_tvalid, s_len_ready, busy);
        end
    endtask

    task automatic test_back_to_back;
        m_axis_tready = 1'b1;
        send_cmd(8);
        n_checks++;
        if ({m_axis_tvalid, m_axis_tkeep, m_axis_tlast, s_len_ready} !== {1'b1, 8'hFF, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b2b_len8: valid=%b keep=%h last=%b ready=%b required 1 ff 1 0",
                     m_axis_tvalid, m_axis_tkeep, m_axis_tlast, s_len_ready);
        end
        n_checks++;
        if (m_axis_tdata !== 64'h0706_0504_0302_0100) begin
            n_fail++; $display("FAIL b2b_len8_data: %h required 0706050403020100", m_axis_tdata);
        end
        // Zero-length command presented while busy must wait.
        s_len = 16'd0;
        s_len_valid = 1'b1;
        tick;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || s_len_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_after8: valid=%b ready=%b required 0 1", m_axis_tvalid, s_len_ready);
        end
        tick;  // zero-length command consumed here
        s_len_valid = 1'b0;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || s_len_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_len0: valid=%b ready=%b busy=%b required 0 1 0",
                     m_axis_tvalid, s_len_ready, busy);
        end
        send_cmd(1);
        n_checks++;
        if ({m_axis_tvalid, m_axis_tkeep, m_axis_tlast, m_axis_tdata} !== {1'b1, 8'h01, 1'b1, 64'h0}) begin
            n_fail++;
            $display("FAIL b2b_len1: valid=%b keep=%h last=%b data=%h required 1 01 1 0",
                     m_axis_tvalid, m_axis_tkeep, m_axis_tlast, m_axis_tdata);
        end
        tick;
        n_checks++;
        if (m_axis_tvalid !== 1'b0 || s_len_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end: valid=%b ready=%b required 0 1", m_axis_tvalid, s_len_ready);
        end
    endtask

    task automatic test_stall;
        int         beats;
        logic [7:0] lk;
        m_axis_tready = 1'b0;
        send_cmd(24);
        collect(24, 1, beats, lk);
        n_checks++;
        if (beats != 3) begin n_fail++; $display("FAIL stall_beats: %0d required 3", beats); end
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL stall_end: tvalid=%b required 0", m_axis_tvalid); end
    endtask

    task automatic test_max_len;
        int         beats;
        logic [7:0] lk;
        m_axis_tready = 1'b1;
        send_cmd(65535);
        collect(65535, 0, beats, lk);
        n_checks++;
        if (beats != 8192) begin n_fail++; $display("FAIL max_beats: %0d required 8192", beats); end
        n_checks++;
        if (lk !== 8'h7F) begin n_fail++; $display("FAIL max_last_keep: %h required 7f", lk); end
        n_checks++;
        if (busy !== 1'b0 || s_len_ready !== 1'b1) begin
            n_fail++; $display("FAIL max_busy: busy=%b ready=%b required 0 1", busy, s_len_ready);
        end
    endtask

    task automatic test_reset_mid_frame;
        m_axis_tready = 1'b1;
        send_cmd(40);
        tick;  // beat 1 accepted
        n_checks++;
        if (m_axis_tdata !== 64'h0F0E_0D0C_0B0A_0908) begin
            n_fail++; $display("FAIL rstmid_beat2: %h required 0f0e0d0c0b0a0908", m_axis_tdata);
        end
        rst = 1'b1;  // coincides with beat 2 handshake
        tick;
        rst = 1'b0;
        n_checks++;
        if ({m_axis_tvalid, busy, s_len_ready} !== 3'b001) begin
            n_fail++;
            $display("FAIL rstmid_state: valid=%b busy=%b ready=%b required 0 0 1",
                     m_axis_tvalid, busy, s_len_ready);
        end
        send_cmd(3);
        n_checks++;
        if ({m_axis_tvalid, m_axis_tkeep, m_axis_tlast, m_axis_tdata} !==
            {1'b1, 8'h07, 1'b1, 64'h0000_0000_0002_0100}) begin
            n_fail++;
            $display("FAIL rstmid_fresh: valid=%b keep=%h last=%b data=%h required 1 07 1 20100",
                     m_axis_tvalid, m_axis_tkeep, m_axis_tlast, m_axis_tdata);
        end
        tick;
        n_checks++;
        if (m_axis_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_end: %b required 0", m_axis_tvalid); end
    endtask

    task automatic test_loopback;
        int         base, len, beats;
        logic [7:0] lk;
        base = mon_count;
        for (int f = 0; f < 200; f++) begin
            len = $urandom_range(1, 300);
            send_cmd(len);
            collect(len, 2, beats, lk);
            n_checks++;
            if (mon_len != len) begin
                n_fail++; $display("FAIL loop_len[%0d]: frame_len=%0d required %0d", f, mon_len, len);
            end
            n_checks++;
            if (mon_count != base + f + 1) begin
                n_fail++; $display("FAIL loop_count[%0d]: %0d required %0d", f, mon_count, base + f + 1);
            end
        end
    endtask

    initial begin
        test_reset;
        test_frame20;
        test_back_to_back;
        test_stall;
        test_max_len;
        test_reset_mid_frame;
        test_loopback;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/axis_frame_len_gen.md
Name: axis_frame_len_gen

Overview:
AXI4-Stream frame generator that sources test frames of a commanded length. It is the transmit-side counterpart of the frame-length monitor.
- A length command (in words, i.e. tkeep lanes) is accepted on a valid/ready handshake.
- One frame of exactly that many words is emitted, with a deterministic data pattern, thermometer tkeep on the final beat, and tlast.
- Used in loopback benches and link bring-up: generator feeds the DUT, the frame-length monitor on the far side checks the length.

Parameters:
DATA_WIDTH, 64, AXI stream data width in bits.
KEEP_ENABLE, (DATA_WIDTH>8), drive tkeep. When 0, tkeep is all ones and each beat carries one word.
KEEP_WIDTH, (DATA_WIDTH/8), number of tkeep lanes (words per beat). Lane width LW = DATA_WIDTH/KEEP_WIDTH.
LEN_WIDTH, 16, width of the length command and internal remaining-word counter.

Ports:
clk  input  1  clock.
rst  input  1  synchronous, active-high reset.
s_len  input  LEN_WIDTH  frame length in words.
s_len_valid  input  1  command valid.
s_len_ready  output  1  command accepted when valid && ready.
m_axis_tdata  output  DATA_WIDTH  frame data.
m_axis_tkeep  output  KEEP_WIDTH  lane enables.
m_axis_tvalid  output  1  beat valid.
m_axis_tready  input  1  sink ready.
m_axis_tlast  output  1  last beat of frame.
busy  output  1  frame in progress.

Behaviour:
- Reset (rst high at a clk edge), values after that edge:
  - m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdata=0.
  - busy=0, s_len_ready=1.
  - State IDLE; remaining counter and word index cleared.
- States: IDLE, SEND.
  - s_len_ready = (state==IDLE); busy = (state==SEND). Both are registered, not combinational from inputs.
- IDLE, command accepted with s_len==0: command consumed, no beat emitted, remain in IDLE.
- IDLE, command accepted with s_len>0 at edge t:
  - Latch rem=s_len and word index w=0; go to SEND.
  - First beat presented with tvalid=1 after edge t (one-cycle latency).
- Beat contents, with n = min(rem, KEEP_WIDTH):
  - tkeep = ({KEEP_WIDTH{1'b1}} >> (KEEP_WIDTH-n)).
  - Lane k<n carries (w+k) mod 2^LW; lanes k>=n are 0.
  - tlast = (rem <= KEEP_WIDTH).
- KEEP_ENABLE=0: n=1, tkeep all ones, the single lane carries w mod 2^DATA_WIDTH.
- Handshake:
  - tvalid, once high, stays high and tdata/tkeep/tlast stay stable until the tready edge (AXI rule).
  - On a tready && tvalid edge: rem -= n, w += n. The next beat is presented in the following cycle with no bubble while rem>0.
- Last beat accepted:
  - tvalid drops after that edge; state returns to IDLE; s_len_ready=1 in the next cycle.
  - Minimum inter-frame gap is therefore 2 cycles (command accept, then first beat).
- s_len_valid while busy: ignored and not accepted. The upstream holds it until s_len_ready.
- Arithmetic:
  - rem and w are LEN_WIDTH bits; w never wraps within a frame because w < s_len <= 2^LEN_WIDTH-1.
  - Beats per frame = ceil(len/KEEP_WIDTH).
- Reset mid-frame: the frame is truncated with no tlast; tvalid is 0 after the reset edge. This takes priority over a simultaneous handshake.
- Round-trip property: the frame-length monitor on the output reports frame_len == commanded s_len for every nonzero command.

Test Plan:
1. DATA_WIDTH=64, s_len=20 -> 3 beats; tkeep 0xFF,0xFF,0x0F; tlast on beat 3 only; lanes carry bytes 0..19; upper 4 bytes of beat 3 are 0; first tvalid one cycle after accept.
2. s_len=8 then s_len=0 then s_len=1 back-to-back -> one beat tkeep 0xFF tlast; no beat for 0; one beat tkeep 0x01 data byte0=0 tlast; s_len_ready low only while busy.
3. s_len=24, tready toggling 1,0,0,1,0,1 -> tdata/tkeep/tlast held stable while tready=0; exactly 3 accepted beats, bytes 0..23, no duplicates or skips.
4. s_len=65535 with tready=1 -> 8192 beats; last tkeep 0x7F, tlast set; byte pattern wraps 0xFF->0x00 every 256 bytes; busy falls after the final beat.
5. rst asserted on beat 2 of an s_len=40 frame -> tvalid=0, busy=0, s_len_ready=1 after the edge; a following s_len=3 command emits a fresh frame starting at data byte 0, tkeep 0x07, tlast.
6. Loopback into the frame-length monitor, random s_len 1..300 x 200 frames, random tready -> each monitor frame_len equals the commanded length and frame_len_valid pulses exactly once per frame.
